hpram_cmd_arbiter: RTL and testbench

Parametrised N-channel arbiter in front of the HyperRAM memory-interface command port (cmd / cmd_en / addr / wr_data / data_mask / rd_data / rd_data_valid / init_calib). It lets several masters share the single controller, for example an AHB bridge and a display framebuffer reader. Each command is a fixed-length burst. Read beats are routed back to the issuing channel. Arbitration is round-robin or fixed-priority, and read bursts are protected by a timeout.

---
 rtl/hpram_cmd_arbiter_pkg.sv | 10 +
 rtl/hpram_cmd_arbiter_if.sv | 34 +++
 rtl/hpram_cmd_arbiter_rr_arbiter.sv | 32 +++
 rtl/hpram_cmd_arbiter.sv | 159 +++++++++++++++
 tb/tb_hpram_cmd_arbiter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/hpram_cmd_arbiter_pkg.sv
// Shared types and constants for the HyperRAM command arbiter.
package hpram_arb_pkg;
  typedef enum logic [1:0] {IDLE, WR, RD, GAP} arb_state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;
endpackage

// File: rtl/hpram_cmd_arbiter_if.sv
// Channel-side and controller-side buses of the arbiter; channel 0 sits in the LSBs.
interface hpram_cmd_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic [NUM_CH-1:0]             ch_req, ch_cmd, ch_gnt, ch_wbeat, ch_rvalid;
  logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] ch_wdata;
  logic [NUM_CH-1:0][MASK_W-1:0] ch_mask;
  logic [DATA_W-1:0]             ch_rdata;

  logic              hp_cmd, hp_cmd_en;
  logic [ADDR_W-1:0] hp_addr;
  logic [DATA_W-1:0] hp_wr_data, hp_rd_data;
  logic [MASK_W-1:0] hp_data_mask;
  logic              hp_rd_data_valid, hp_init_calib;

  // master: the arbiter; slave: requesters plus the memory controller
  modport master (
    input  ch_req, ch_cmd, ch_addr, ch_wdata, ch_mask,
           hp_rd_data, hp_rd_data_valid, hp_init_calib,
    output ch_gnt, ch_wbeat, ch_rvalid, ch_rdata,
           hp_cmd, hp_cmd_en, hp_addr, hp_wr_data, hp_data_mask
  );
  modport slave (
    output ch_req, ch_cmd, ch_addr, ch_wdata, ch_mask,
           hp_rd_data, hp_rd_data_valid, hp_init_calib,
    input  ch_gnt, ch_wbeat, ch_rvalid, ch_rdata,
           hp_cmd, hp_cmd_en, hp_addr, hp_wr_data, hp_data_mask
  );
endinterface

// File: rtl/hpram_cmd_arbiter_rr_arbiter.sv
// Combinational one-hot picker: round-robin from ptr, or fixed priority from channel 0.
module rr_arbiter
  import hpram_arb_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ARB_MODE = ARB_RR,
  localparam int PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [PTR_W-1:0]  nxt_ptr
);
  always_comb begin
    int   base;
    int   c;
    logic found;
    gnt     = '0;
    nxt_ptr = '0;
    found   = 1'b0;
    c       = 0;
    base    = (ARB_MODE == ARB_RR) ? int'(ptr) : 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = (base + i) % NUM_CH;
      if (!found && req[c]) begin
        found   = 1'b1;
        gnt[c]  = 1'b1;
        nxt_ptr = (c == NUM_CH - 1) ? '0 : PTR_W'(c + 1);
      end
    end
  end
endmodule

// File: rtl/hpram_cmd_arbiter.sv
// N-channel fixed-burst command arbiter in front of the HyperRAM controller user port.
module hpram_cmd_arbiter
  import hpram_arb_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 22,
  parameter int DATA_W      = 32,
  parameter int BURST_BEATS = 4,
  parameter int CMD_GAP     = 2,
  parameter int RD_TIMEOUT  = 255,
  parameter int ARB_MODE    = ARB_RR
) (
  input  logic                clk,
  input  logic                reset,
  hpram_cmd_arbiter_if.master bus,
  output logic                busy,
  output logic                err_timeout,
  input  logic                err_clr
);
  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW     = $clog2(BURST_BEATS + 1);
  localparam int GW     = (CMD_GAP > 0) ? $clog2(CMD_GAP + 1) : 1;
  localparam int TW     = $clog2(RD_TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  logic              settle_q;
  logic [PTR_W-1:0]  rr_ptr, nxt_ptr;
  logic [NUM_CH-1:0] arb_gnt, own_q;
  logic [BW-1:0]     beat_q;
  logic [GW-1:0]     gap_q;
  logic [TW-1:0]     tmo_q;
  logic              grant, burst_end, rd_beat, rd_to, wr_more, sel_cmd;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata, own_wdata;
  logic [MASK_W-1:0] sel_mask, own_mask;

  rr_arbiter #(.NUM_CH(NUM_CH), .ARB_MODE(ARB_MODE)) u_arb (
    .req(bus.ch_req), .ptr(rr_ptr), .gnt(arb_gnt), .nxt_ptr(nxt_ptr)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_mask  = '0;
    own_wdata = '0;
    own_mask  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_gnt[i]) begin
        sel_addr  |= bus.ch_addr[i];
        sel_wdata |= bus.ch_wdata[i];
        sel_mask  |= bus.ch_mask[i];
      end
      if (own_q[i]) begin
        own_wdata |= bus.ch_wdata[i];
        own_mask  |= bus.ch_mask[i];
      end
    end
  end

  assign sel_cmd = |(bus.ch_cmd & arb_gnt);
  assign busy    = (state_q != IDLE);

  // settle_q holds off grants for one IDLE cycle after every burst
  always_comb begin
    state_d      = state_q;
    bus.ch_gnt   = '0;
    bus.ch_wbeat = '0;
    grant        = 1'b0;
    burst_end    = 1'b0;
    rd_beat      = 1'b0;
    rd_to        = 1'b0;
    wr_more      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.hp_init_calib && |bus.ch_req && !settle_q && !reset) begin
          grant      = 1'b1;
          bus.ch_gnt = arb_gnt;
          if (sel_cmd == CMD_WRITE) bus.ch_wbeat = arb_gnt;
          state_d = (sel_cmd == CMD_WRITE) ? WR : RD;
        end
      end
      WR: begin
        if (beat_q != BW'(BURST_BEATS - 1)) begin
          wr_more      = 1'b1;
          bus.ch_wbeat = own_q;
        end else begin
          burst_end = 1'b1;
        end
      end
      RD: begin
        rd_beat = bus.hp_rd_data_valid;
        if (rd_beat && beat_q == BW'(BURST_BEATS - 1)) begin
          burst_end = 1'b1;
        end else if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
          burst_end = 1'b1;
          rd_to     = 1'b1;
        end
      end
      GAP: if (gap_q == GW'(CMD_GAP - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (burst_end) state_d = (CMD_GAP == 0) ? IDLE : GAP;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      settle_q         <= 1'b0;
      rr_ptr           <= '0;
      own_q            <= '0;
      beat_q           <= '0;
      gap_q            <= '0;
      tmo_q            <= '0;
      err_timeout      <= 1'b0;
      bus.hp_cmd       <= 1'b0;
      bus.hp_cmd_en    <= 1'b0;
      bus.hp_addr      <= '0;
      bus.hp_wr_data   <= '0;
      bus.hp_data_mask <= '0;
      bus.ch_rdata     <= '0;
      bus.ch_rvalid    <= '0;
    end else begin
      state_q       <= state_d;
      settle_q      <= (state_q != IDLE) && (state_d == IDLE);
      bus.hp_cmd_en <= grant;
      bus.ch_rvalid <= '0;
      if (grant) begin
        own_q            <= arb_gnt;
        beat_q           <= '0;
        gap_q            <= '0;
        tmo_q            <= '0;
        bus.hp_cmd       <= sel_cmd;
        bus.hp_addr      <= sel_addr;
        bus.hp_wr_data   <= sel_wdata;
        bus.hp_data_mask <= sel_mask;
        if (ARB_MODE == ARB_RR) rr_ptr <= nxt_ptr;
      end
      if (state_q == WR) begin
        beat_q <= beat_q + BW'(1);
        if (wr_more) begin
          bus.hp_wr_data   <= own_wdata;
          bus.hp_data_mask <= own_mask;
        end
      end
      if (state_q == RD) begin
        tmo_q <= tmo_q + TW'(1);
        if (rd_beat) begin
          beat_q        <= beat_q + BW'(1);
          bus.ch_rdata  <= bus.hp_rd_data;
          bus.ch_rvalid <= own_q;
        end
      end
      if (state_q == GAP) gap_q <= gap_q + GW'(1);
      if (rd_to)        err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hpram_cmd_arbiter.sv
// Directed bench: calibration gate, write beats, read routing, round-robin, timeout, mid-burst reset.
module tb_hpram_cmd_arbiter;
  import hpram_arb_pkg::*;

  localparam int NCH = 2, AW = 22, DW = 32;

  logic        clk, reset, busy, err_timeout, err_clr;
  logic [31:0] wp0, wp1;
  int          checks = 0, errors = 0;
  int          cnt0, cnt1, gcnt, d;
  logic        pv;
  logic [31:0] pd;

  hpram_cmd_arbiter_if #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW)) bus();

  hpram_cmd_arbiter #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .BURST_BEATS(4),
    .CMD_GAP(2), .RD_TIMEOUT(20), .ARB_MODE(ARB_RR)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FWFT write sources: ch0 emits A0,A1,..., ch1 emits B0,B1,...
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wp0 <= 0;
      wp1 <= 0;
    end else begin
      if (bus.ch_wbeat[0]) wp0 <= wp0 + 1;
      if (bus.ch_wbeat[1]) wp1 <= wp1 + 1;
    end
  end
  always_comb begin
    bus.ch_wdata[0] = 32'hA0 + wp0;
    bus.ch_wdata[1] = 32'hB0 + wp1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 40 && busy; k++) cyc();
    chk("idle_reached", busy, 0);
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    err_clr = 1'b0;
    bus.ch_req = '0;
    bus.ch_cmd = '0;
    bus.ch_addr[0] = 22'h001234;
    bus.ch_addr[1] = 22'h002AAA;
    bus.ch_mask[0] = 4'h3;
    bus.ch_mask[1] = 4'hC;
    bus.hp_rd_data = '0;
    bus.hp_rd_data_valid = 1'b0;
    bus.hp_init_calib = 1'b0;
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_cmd_en", bus.hp_cmd_en, 0);
    chk("rst_rvalid", bus.ch_rvalid, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_wdata", bus.hp_wr_data, 0);
    reset = 1'b0;

    // calibration gate + ch0 write beats
    bus.ch_req = 2'b01;
    bus.ch_cmd = 2'b01;
    gcnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(); #2;
      if (bus.ch_gnt != 0) gcnt++;
    end
    chk("calib_no_gnt", gcnt, 0);
    cyc();
    bus.hp_init_calib = 1'b1;
    #2;
    chk("calib_gnt", bus.ch_gnt, 2'b01);
    cnt0 = bus.ch_wbeat[0] ? 1 : 0;
    cyc();
    bus.ch_req = 2'b00;
    #2;
    chk("wr_cmd_en", bus.hp_cmd_en, 1);
    chk("wr_cmd", bus.hp_cmd, 1);
    chk("wr_addr", bus.hp_addr, 22'h001234);
    chk("wr_mask", bus.hp_data_mask, 4'h3);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin cyc(); #2; end
      chk("wr_data", bus.hp_wr_data, 32'hA0 + b);
      if (b == 1) chk("wr_cmd_en_once", bus.hp_cmd_en, 0);
      if (bus.ch_wbeat[0]) cnt0++;
    end
    for (int i = 0; i < 4; i++) begin
      cyc(); #2;
      if (bus.ch_wbeat[0]) cnt0++;
    end
    chk("wr_wbeat_cnt", cnt0, 4);
    wait_idle();

    // ch1 read, beats with holes
    bus.ch_req = 2'b10;
    bus.ch_cmd = 2'b00;
    #2;
    chk("rd_gnt", bus.ch_gnt, 2'b10);
    chk("rd_no_wbeat", bus.ch_wbeat, 0);
    cyc();
    bus.ch_req = 2'b00;
    #2;
    chk("rd_cmd_en", bus.hp_cmd_en, 1);
    chk("rd_cmd", bus.hp_cmd, 0);
    chk("rd_addr", bus.hp_addr, 22'h002AAA);
    pv = 1'b0; pd = '0; cnt0 = 0; cnt1 = 0;
    for (int t = 1; t <= 9; t++) begin
      cyc();
      bus.hp_rd_data_valid = (t % 2 == 1) && (t <= 7);
      bus.hp_rd_data = 32'hC0DE0000 + t;
      #2;
      chk("rd_rvalid", bus.ch_rvalid, pv ? 2'b10 : 2'b00);
      if (pv) chk("rd_rdata", bus.ch_rdata, pd);
      if (bus.ch_rvalid[0]) cnt0++;
      if (bus.ch_rvalid[1]) cnt1++;
      pv = bus.hp_rd_data_valid;
      pd = bus.hp_rd_data;
    end
    bus.hp_rd_data_valid = 1'b0;
    chk("rd_cnt1", cnt1, 4);
    chk("rd_cnt0", cnt0, 0);
    wait_idle();

    // round-robin, continuous write requests
    bus.ch_req = 2'b11;
    bus.ch_cmd = 2'b11;
    #2;
    chk("rr_gnt0", bus.ch_gnt, 2'b01);
    for (int n = 1; n < 4; n++) begin
      d = 0;
      do begin cyc(); #2; d++; end while (bus.ch_gnt == 0 && d < 20);
      chk("rr_spacing", d, 8);
      chk("rr_gnt", bus.ch_gnt, (n % 2 == 1) ? 2'b10 : 2'b01);
    end
    cyc();
    bus.ch_req = 2'b00;
    wait_idle();

    // ch0 read timeout: two beats only, then a late one
    bus.ch_req = 2'b01;
    bus.ch_cmd = 2'b00;
    #2;
    chk("to_gnt", bus.ch_gnt, 2'b01);
    cyc();
    bus.ch_req = 2'b00;
    cnt0 = 0;
    for (int r = 1; r <= 25; r++) begin
      cyc();
      bus.hp_rd_data_valid = (r == 2) || (r == 4) || (r == 21);
      bus.hp_rd_data = 32'h5500 + r;
      err_clr = (r == 23);
      #2;
      if (bus.ch_rvalid[0]) cnt0++;
      if (r == 19) chk("to_err_before", err_timeout, 0);
      if (r == 20) chk("to_err_set", err_timeout, 1);
      if (r == 22) chk("to_late_drop", bus.ch_rvalid, 0);
      if (r == 23) chk("to_err_held", err_timeout, 1);
      if (r == 24) chk("to_err_clr", err_timeout, 0);
    end
    bus.hp_rd_data_valid = 1'b0;
    err_clr = 1'b0;
    chk("to_beats", cnt0, 2);
    wait_idle();

    // mid-burst reset during WR beat 2 (rr_ptr is 1 beforehand)
    bus.ch_req = 2'b01;
    bus.ch_cmd = 2'b01;
    #2;
    chk("mr_gnt", bus.ch_gnt, 2'b01);
    cyc();
    bus.ch_req = 2'b00;
    cyc(); cyc();
    bus.ch_req = 2'b11;
    bus.ch_cmd = 2'b11;
    reset = 1'b1;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_gnt_rst", bus.ch_gnt, 0);
    chk("mr_wbeat_rst", bus.ch_wbeat, 0);
    chk("mr_cmd_en", bus.hp_cmd_en, 0);
    chk("mr_wdata", bus.hp_wr_data, 0);
    chk("mr_addr", bus.hp_addr, 0);
    cyc();
    reset = 1'b0;
    #2;
    chk("mr_restart_gnt", bus.ch_gnt, 2'b01);
    cyc();
    bus.ch_req = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
